// File: rtl/axis_stall_detector.sv
// axis_stall_detector
// Per-channel AXI-Stream stall watchdog feeding the deadlock monitor.
// Each channel has a saturating counter of consecutive stalled cycles; the
// block flag is decoded straight from that counter. Rising flags are
// counted, and the lowest-index channel of the first rising set is held
// until clear.
//
// Handshake semantics: a beat moves on a side when valid & ready are both
// high in the same cycle. A write side is stalled when wr_valid is high and
// wr_ready is low (FIFO full). A read side is stalled when rd_ready is high
// and rd_valid is low (FIFO empty). A beat on either side counts as progress
// and overrides any stall on the other side.
module axis_stall_detector #(
   parameter int NUM_CH = 14,
   parameter int CNT_W  = 16,
   parameter int THRESH = 1024,
   parameter int IDX_W  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear,
   input  logic [NUM_CH-1:0] wr_valid,
   input  logic [NUM_CH-1:0] wr_ready,
   input  logic [NUM_CH-1:0] rd_valid,
   input  logic [NUM_CH-1:0] rd_ready,
   output logic [NUM_CH-1:0] axis_block_sigs,
   output logic              any_block,
   output logic              first_block_valid,
   output logic [IDX_W-1:0]  first_block_idx,
   output logic [CNT_W-1:0]  block_event_count
);

   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   logic [NUM_CH-1:0] progress;
   logic [NUM_CH-1:0] stalled;
   logic [NUM_CH-1:0] block_prev;
   logic [NUM_CH-1:0] rise;
   logic [CNT_W-1:0]  stall_cnt [NUM_CH];

   logic              rise_any;
   logic [IDX_W-1:0]  rise_idx;
   logic [CNT_W:0]    rise_pop;
   logic [CNT_W-1:0]  event_base;
   logic [CNT_W:0]    event_sum;
   logic [CNT_W-1:0]  event_next;

   assign progress = (wr_valid & wr_ready) | (rd_valid & rd_ready);
   assign stalled  = ((wr_valid & ~wr_ready) | (rd_ready & ~rd_valid)) & ~progress;

   // Count consecutive stalled cycles per channel, saturating at THRESH.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset || !enable || !stalled[i]) begin
            stall_cnt[i] <= '0;
         end else if (stall_cnt[i] != THRESH_C) begin
            stall_cnt[i] <= stall_cnt[i] + 1'b1;
         end
      end
   end

   // Block flag is a pure decode of the counter register.
   always_comb begin
      axis_block_sigs = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         axis_block_sigs[i] = (stall_cnt[i] == THRESH_C);
      end
   end

   assign any_block = |axis_block_sigs;

   // Registered copy of the flags for rising-edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         block_prev <= '0;
      end else begin
         block_prev <= axis_block_sigs;
      end
   end

   assign rise = axis_block_sigs & ~block_prev;

   // Lowest rising index, popcount of rises and saturated event total.
   always_comb begin
      rise_any   = |rise;
      rise_idx   = '0;
      rise_pop   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rise[i]) begin
            rise_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         rise_pop = rise_pop + (CNT_W+1)'(rise[i]);
      end
      event_base = clear ? '0 : block_event_count;
      event_sum  = {1'b0, event_base} + rise_pop;
      event_next = event_sum[CNT_W] ? {CNT_W{1'b1}} : event_sum[CNT_W-1:0];
   end

   // Sticky first-block capture and event counter; clear re-arms capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         first_block_valid <= 1'b0;
         first_block_idx   <= '0;
         block_event_count <= '0;
      end else begin
         block_event_count <= event_next;
         if (clear) begin
            first_block_valid <= rise_any;
            first_block_idx   <= rise_any ? rise_idx : '0;
         end else if (!first_block_valid && rise_any) begin
            first_block_valid <= 1'b1;
            first_block_idx   <= rise_idx;
         end
      end
   end

endmodule

// File: tb/tb_axis_stall_detector.sv
// tb_axis_stall_detector
// Directed scenarios plus a random run. A behavioural model advances with
// every clock and pushes the expected output word to exp_q; the DUT's word
// is captured at the same point and each scenario task pops and compares.
module tb_axis_stall_detector;

  localparam int NUM_CH = 14;
  localparam int CNT_W  = 16;
  localparam int THRESH = 4;
  localparam int IDX_W  = 4;
  localparam int W      = NUM_CH + 1 + 1 + IDX_W + CNT_W;
  localparam int EV_MAX = 65535;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset, enable, clear;
  logic [NUM_CH-1:0] wr_valid, wr_ready, rd_valid, rd_ready;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic              first_block_valid;
  logic [IDX_W-1:0]  first_block_idx;
  logic [CNT_W-1:0]  block_event_count;

  always #5 clock = ~clock;

  axis_stall_detector #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .THRESH(THRESH), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .axis_block_sigs(axis_block_sigs), .any_block(any_block),
    .first_block_valid(first_block_valid), .first_block_idx(first_block_idx),
    .block_event_count(block_event_count)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int                m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_prev;
  logic              m_fv;
  logic [IDX_W-1:0]  m_idx;
  int                m_ev;

  function automatic logic [W-1:0] model_out();
    logic [NUM_CH-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_CH; i++) f[i] = (m_cnt[i] == THRESH);
    return {f, |f, m_fv, m_idx, CNT_W'(m_ev)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    enable = 1'b1; clear = 1'b0;
    wr_valid = '0; wr_ready = '0; rd_valid = '0; rd_ready = '0;
  endtask

  // One clock: advance the model on the current inputs, push expectation,
  // capture the DUT word after the edge.
  task automatic tick();
    logic [NUM_CH-1:0] f, rise;
    int lo, pc;
    bit st;
    f = '0;
    for (int i = 0; i < NUM_CH; i++) f[i] = (m_cnt[i] == THRESH);
    rise = f & ~m_prev;
    pc = $countones(rise);
    lo = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (rise[i]) lo = i;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      m_prev = '0; m_fv = 1'b0; m_idx = '0; m_ev = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st = ((wr_valid[i] && !wr_ready[i]) || (rd_ready[i] && !rd_valid[i]))
             && !(wr_valid[i] && wr_ready[i]) && !(rd_valid[i] && rd_ready[i]);
        if (!enable || !st) m_cnt[i] = 0;
        else if (m_cnt[i] < THRESH) m_cnt[i] = m_cnt[i] + 1;
      end
      m_prev = f;
      if (clear) begin
        m_fv  = (rise != 0);
        m_idx = (rise != 0) ? IDX_W'(lo) : '0;
        m_ev  = (pc > EV_MAX) ? EV_MAX : pc;
      end else begin
        if (!m_fv && rise != 0) begin
          m_fv = 1'b1;
          m_idx = IDX_W'(lo);
        end
        m_ev = (m_ev + pc > EV_MAX) ? EV_MAX : m_ev + pc;
      end
    end
    @(posedge clock);
    #1;
    exp_q.push_back(model_out());
    obs_q.push_back({axis_block_sigs, any_block, first_block_valid,
                     first_block_idx, block_event_count});
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [W-1:0] e, o;
    do_reset();
    repeat (10) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset_cycle: got %h expected %h", o, e); end
    end
    n_vec++;
    if ({axis_block_sigs, any_block, first_block_valid, first_block_idx, block_event_count} !== '0) begin
      n_err++; $display("FAIL reset_all_zero: got %h expected 0",
        {axis_block_sigs, any_block, first_block_valid, first_block_idx, block_event_count});
    end
  endtask

  task automatic test_single_stall();
    logic [W-1:0] e, o;
    do_reset();
    wr_valid[3] = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (axis_block_sigs !== 14'h0000) begin n_err++; $display("FAIL ch3_early: got %h expected 0000", axis_block_sigs); end
    tick();
    n_vec++;
    if (axis_block_sigs !== 14'h0008) begin n_err++; $display("FAIL ch3_flag: got %h expected 0008", axis_block_sigs); end
    tick();
    n_vec++;
    if ({first_block_valid, first_block_idx, block_event_count} !== {1'b1, 4'd3, 16'd1}) begin
      n_err++; $display("FAIL ch3_capture: got v=%b idx=%0d cnt=%0d expected v=1 idx=3 cnt=1",
        first_block_valid, first_block_idx, block_event_count);
    end
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL single_stall_cycle: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_progress_restart();
    logic [W-1:0] e, o;
    do_reset();
    rd_ready[5] = 1'b1;
    repeat (3) tick();
    rd_valid[5] = 1'b1;
    tick();
    rd_valid[5] = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (axis_block_sigs !== 14'h0000) begin n_err++; $display("FAIL ch5_restart: got %h expected 0000", axis_block_sigs); end
    tick();
    n_vec++;
    if (axis_block_sigs !== 14'h0020) begin n_err++; $display("FAIL ch5_flag: got %h expected 0020", axis_block_sigs); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL progress_cycle: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] e, o;
    do_reset();
    wr_valid[2] = 1'b1;
    rd_ready[9] = 1'b1;
    repeat (4) tick();
    n_vec++;
    if (axis_block_sigs !== 14'h0204 || any_block !== 1'b1) begin
      n_err++; $display("FAIL ch2_9_flag: got %h any=%b expected 0204 any=1", axis_block_sigs, any_block);
    end
    tick();
    n_vec++;
    if ({first_block_valid, first_block_idx, block_event_count} !== {1'b1, 4'd2, 16'd2}) begin
      n_err++; $display("FAIL ch2_9_capture: got v=%b idx=%0d cnt=%0d expected v=1 idx=2 cnt=2",
        first_block_valid, first_block_idx, block_event_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL simultaneous_cycle: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_other_side_progress();
    logic [W-1:0] e, o;
    do_reset();
    wr_valid[7] = 1'b1;
    repeat (5) tick();
    rd_valid[7] = 1'b1; rd_ready[7] = 1'b1;
    tick();
    n_vec++;
    if (axis_block_sigs !== 14'h0000) begin n_err++; $display("FAIL ch7_drop: got %h expected 0000", axis_block_sigs); end
    rd_valid[7] = 1'b0; rd_ready[7] = 1'b0;
    repeat (5) tick();
    n_vec++;
    if ({axis_block_sigs, first_block_idx, block_event_count} !== {14'h0080, 4'd7, 16'd2}) begin
      n_err++; $display("FAIL ch7_rerise: got blk=%h idx=%0d cnt=%0d expected blk=0080 idx=7 cnt=2",
        axis_block_sigs, first_block_idx, block_event_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL other_side_cycle: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_clear_with_rise();
    logic [W-1:0] e, o;
    do_reset();
    wr_valid[1] = 1'b1;
    repeat (6) tick();
    wr_valid[11] = 1'b1;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_vec++;
    if ({axis_block_sigs, first_block_valid, first_block_idx, block_event_count} !== {14'h0802, 1'b1, 4'd11, 16'd1}) begin
      n_err++; $display("FAIL clear_rise: got blk=%h v=%b idx=%0d cnt=%0d expected blk=0802 v=1 idx=11 cnt=1",
        axis_block_sigs, first_block_valid, first_block_idx, block_event_count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_vec++;
    if ({axis_block_sigs, first_block_valid, first_block_idx, block_event_count} !== {14'h0802, 1'b0, 4'd0, 16'd0}) begin
      n_err++; $display("FAIL clear_plain: got blk=%h v=%b idx=%0d cnt=%0d expected blk=0802 v=0 idx=0 cnt=0",
        axis_block_sigs, first_block_valid, first_block_idx, block_event_count);
    end
    enable = 1'b0;
    tick();
    n_vec++;
    if (axis_block_sigs !== 14'h0000 || any_block !== 1'b0) begin
      n_err++; $display("FAIL enable_low: got %h any=%b expected 0000 any=0", axis_block_sigs, any_block);
    end
    enable = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL clear_cycle: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [W-1:0] e, o;
    do_reset();
    wr_valid[0] = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({axis_block_sigs, any_block, first_block_valid, first_block_idx, block_event_count} !== '0) begin
      n_err++; $display("FAIL mid_reset: got blk=%h v=%b cnt=%0d expected all 0",
        axis_block_sigs, first_block_valid, block_event_count);
    end
    repeat (3) tick();
    n_vec++;
    if (axis_block_sigs !== 14'h0000) begin n_err++; $display("FAIL mid_reset_early: got %h expected 0000", axis_block_sigs); end
    tick();
    n_vec++;
    if (axis_block_sigs !== 14'h0001) begin n_err++; $display("FAIL mid_reset_reflag: got %h expected 0001", axis_block_sigs); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL mid_reset_cycle: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, o;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_valid[i] = ($urandom_range(0, 3) != 0);
        wr_ready[i] = ($urandom_range(0, 11) == 0);
        rd_valid[i] = ($urandom_range(0, 11) == 0);
        rd_ready[i] = ($urandom_range(0, 1) == 1);
      end
      clear  = ($urandom_range(0, 29) == 0);
      enable = ($urandom_range(0, 49) != 0);
      tick();
    end
    idle_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL random_cycle: got %h expected %h", o, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    m_prev = '0; m_fv = 1'b0; m_idx = '0; m_ev = 0;
    test_reset();
    test_single_stall();
    test_progress_restart();
    test_simultaneous();
    test_other_side_progress();
    test_clear_with_rise();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_stall_detector.md
Name: axis_stall_detector

Overview:
- Generates the per-channel AXI-Stream block vector consumed by the top-level deadlock monitor in the correlator co-simulation harness.
- Watches the write and read handshakes of every inter-process AXIS FIFO channel.
- Flags a channel once it has been blocked, with no progress, for THRESH consecutive cycles.
- Also records which channel blocked first and counts block events for end-of-sim reporting.

Parameters:
NUM_CH, 14, number of monitored AXIS channels (width of the block vector).
CNT_W, 16, width of the per-channel stall counters and the event counter.
THRESH, 1024, consecutive blocked cycles before a channel is flagged; legal range 1 to 2^CNT_W-1.
IDX_W, 4, width of first_block_idx; must satisfy 2^IDX_W >= NUM_CH.

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  monitoring enable; low holds all counters and flags at 0
clear  input  1  one-cycle pulse; clears sticky first-block capture and event counter
wr_valid  input  NUM_CH  producer write attempt per channel
wr_ready  input  NUM_CH  FIFO not full per channel
rd_valid  input  NUM_CH  FIFO not empty per channel
rd_ready  input  NUM_CH  consumer read attempt per channel
axis_block_sigs  output  NUM_CH  per-channel blocked flag (to deadlock monitor)
any_block  output  1  OR of axis_block_sigs
first_block_valid  output  1  sticky: a first-block capture is held
first_block_idx  output  IDX_W  lowest-index channel among the first set of channels to flag
block_event_count  output  CNT_W  saturating count of rising edges on any axis_block_sigs bit

Behaviour:
- Reset: all counters 0, axis_block_sigs 0, any_block 0, first_block_valid 0, first_block_idx 0, block_event_count 0. Reset mid-operation discards all state in one cycle.
- Per channel i, evaluated each cycle:
  - progress = (wr_valid & wr_ready) | (rd_valid & rd_ready)
  - stalled = ((wr_valid & ~wr_ready) | (rd_ready & ~rd_valid)) & ~progress
- Counter update:
  - enable=0 or stalled=0: counter <= 0.
  - stalled=1: counter <= counter+1, saturating at THRESH.
  - Progress on either side of a channel clears its counter, even if the other side is stalled.
- Flag: axis_block_sigs[i] = (counter[i] == THRESH), decoded directly from the counter register.
  - It rises in the cycle after the THRESH-th consecutive stalled cycle.
  - It falls in the cycle after the first non-stalled cycle.
- any_block is the combinational OR of axis_block_sigs.
- Rise detection: rise[i] = axis_block_sigs[i] & ~prev[i], where prev is the registered copy of axis_block_sigs; prev resets to 0.
- First-block capture:
  - When first_block_valid=0 and any rise bit is set, next cycle first_block_valid=1 and first_block_idx = lowest set index.
  - Further rises are ignored until clear.
- Clear:
  - clear=1 zeroes first_block_valid, first_block_idx and block_event_count.
  - If a rise coincides with clear, the new capture is stored (valid=1, idx=lowest rising index) and block_event_count <= popcount(rise), saturating.
  - clear does not affect stall counters or flags.
- Event counter: block_event_count += popcount(rise) each cycle, saturating at 2^CNT_W-1.
- enable falling: counters and flags drop to 0 on the next edge; first-block and event state are retained.

Test Plan (THRESH=4, NUM_CH=14):
- Reset release, all inputs 0, 10 cycles -> all outputs 0.
- Ch3 wr_valid=1, wr_ready=0 held -> axis_block_sigs=0x0008 after the 4th edge and stays high; first_block_valid=1, first_block_idx=3, block_event_count=1 one cycle later.
- Ch5 rd_ready=1, rd_valid=0 for 3 cycles, then rd_valid=1 for 1 cycle, then 0 again -> no flag until 4 further stalled cycles; count restarts from 0.
- Ch2 and ch9 stall starting the same cycle -> both flags rise together; first_block_idx=2; block_event_count=2.
- Ch7 flagged, ch7 wr side stalled while rd side handshakes -> flag drops the next cycle; rise again after re-stall adds 1 to block_event_count; first_block_idx unchanged.
- Ch1 flagged and held, then clear pulse coincident with ch11 rise -> first_block_idx=11, block_event_count=1. Separately, reset asserted mid-stall -> all outputs 0 the next cycle; the stall needs 4 fresh cycles to re-flag.
